mem_req_initiator: RTL

RTL initiator for the memory-transaction protocol. It takes read/write commands from a local command port and issues one tagged request at a time to the handler chain / memory responder. It then waits for the matching response and retries on a busy status. It enforces a response timeout and returns a completion with read data and final status.

---
 rtl/mem_req_initiator.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_req_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_req_initiator                                            |
// | Description : Takes read/write commands from a local command port, issues  |
// |               one tagged request at a time to the responder chain, waits   |
// |               for the matching response, re-issues on RETRY, enforces a    |
// |               response timeout and returns a one-cycle completion.         |
// | Options     : define MEM_REQ_INITIATOR_STATS_EN to add the saturating      |
// |               stat_done / stat_err / stat_retry counters.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_req_initiator #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 4,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   // command port
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // request port
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   output logic [TAG_W-1:0]  req_tag,
   // response port (always accepted)
   input  logic              rsp_valid,
   input  logic [TAG_W-1:0]  rsp_tag,
   input  logic [1:0]        rsp_status,
   input  logic [DATA_W-1:0] rsp_rdata,
   // completion port
   output logic              done_valid,
   output logic [2:0]        done_status,
   output logic [DATA_W-1:0] done_rdata
`ifdef MEM_REQ_INITIATOR_STATS_EN
   ,
   output logic [15:0]       stat_done,
   output logic [15:0]       stat_err,
   output logic [15:0]       stat_retry
`endif
);

   // The handshake cycle counts as the first cycle of the response window,
   // so the timer holds the number of WAIT cycles still allowed.
   localparam int                 CNT_W    = $clog2(TIMEOUT);
   localparam int                 RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [CNT_W-1:0]   TMR_LOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   TMR_LAST = CNT_W'(1);
   localparam logic [RTY_W-1:0]   RTY_MAX  = RTY_W'(MAX_RETRY);

   localparam logic [1:0]         RSP_OK    = 2'b00;
   localparam logic [1:0]         RSP_RETRY = 2'b11;

   localparam logic [2:0]         DONE_RETRY_EXH = 3'd3;
   localparam logic [2:0]         DONE_TIMEOUT   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q,       state_d;
   logic                cmd_ready_q,   cmd_ready_d;
   logic                write_q,       write_d;
   logic [ADDR_W-1:0]   addr_q,        addr_d;
   logic [DATA_W-1:0]   wdata_q,       wdata_d;
   logic [TAG_W-1:0]    tag_q,         tag_d;
   logic [RTY_W-1:0]    retry_q,       retry_d;
   logic [CNT_W-1:0]    timer_q,       timer_d;
   logic [2:0]          done_status_q, done_status_d;
   logic [DATA_W-1:0]   done_rdata_q,  done_rdata_d;

   logic                w_rsp_match;

   assign w_rsp_match = rsp_valid && (rsp_tag == tag_q);

   // State register and latched transaction context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         tag_q         <= '0;
         retry_q       <= '0;
         timer_q       <= '0;
         done_status_q <= '0;
         done_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         tag_q         <= tag_d;
         retry_q       <= retry_d;
         timer_q       <= timer_d;
         done_status_q <= done_status_d;
         done_rdata_q  <= done_rdata_d;
      end
   end

   // Next-state logic: accept, issue, wait/retry/timeout, complete
   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      tag_d         = tag_q;
      retry_d       = retry_q;
      timer_d       = timer_q;
      done_status_d = done_status_q;
      done_rdata_d  = done_rdata_q;

      case (state_q)
         ST_IDLE: begin
            // cmd_ready is registered, so it is low in the first cycle
            // after reset release and no command is taken then
            if (cmd_valid && cmd_ready_q) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               retry_d = '0;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (req_ready) begin
               timer_d = TMR_LOAD;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            timer_d = timer_q - CNT_W'(1);
            // A matching response has priority over an expiring timer
            if (w_rsp_match) begin
               if (rsp_status == RSP_RETRY) begin
                  // Every RETRY retires the tag, whether re-issued or not
                  tag_d = tag_q + TAG_W'(1);
                  if (retry_q < RTY_MAX) begin
                     retry_d = retry_q + RTY_W'(1);
                     state_d = ST_ISSUE;
                  end else begin
                     done_status_d = DONE_RETRY_EXH;
                     done_rdata_d  = '0;
                     state_d       = ST_DONE;
                  end
               end else begin
                  done_status_d = {1'b0, rsp_status};
                  done_rdata_d  = ((rsp_status == RSP_OK) && !write_q) ? rsp_rdata : '0;
                  state_d       = ST_DONE;
               end
            end else if (timer_q == TMR_LAST) begin
               tag_d         = tag_q + TAG_W'(1);
               done_status_d = DONE_TIMEOUT;
               done_rdata_d  = '0;
               state_d       = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   assign cmd_ready   = cmd_ready_q;
   assign req_valid   = (state_q == ST_ISSUE);
   assign req_write   = write_q;
   assign req_addr    = addr_q;
   assign req_wdata   = wdata_q;
   assign req_tag     = tag_q;
   assign done_valid  = (state_q == ST_DONE);
   assign done_status = done_status_q;
   assign done_rdata  = done_rdata_q;

`ifdef MEM_REQ_INITIATOR_STATS_EN
   logic [15:0] stat_done_q,  stat_done_d;
   logic [15:0] stat_err_q,   stat_err_d;
   logic [15:0] stat_retry_q, stat_retry_d;
   logic        w_complete;
   logic        w_reissue;

   assign w_complete = (state_q == ST_DONE);
   assign w_reissue  = (state_q == ST_WAIT) && (state_d == ST_ISSUE);

   // Statistics counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_done_q  <= '0;
         stat_err_q   <= '0;
         stat_retry_q <= '0;
      end else begin
         stat_done_q  <= stat_done_d;
         stat_err_q   <= stat_err_d;
         stat_retry_q <= stat_retry_d;
      end
   end

   // Saturating increments for completions, error completions and re-issues
   always_comb begin
      stat_done_d  = stat_done_q;
      stat_err_d   = stat_err_q;
      stat_retry_d = stat_retry_q;
      if (w_complete && (stat_done_q != 16'hFFFF)) begin
         stat_done_d = stat_done_q + 16'd1;
      end
      if (w_complete && (done_status_q != 3'd0) && (stat_err_q != 16'hFFFF)) begin
         stat_err_d = stat_err_q + 16'd1;
      end
      if (w_reissue && (stat_retry_q != 16'hFFFF)) begin
         stat_retry_d = stat_retry_q + 16'd1;
      end
   end

   assign stat_done  = stat_done_q;
   assign stat_err   = stat_err_q;
   assign stat_retry = stat_retry_q;
`endif

endmodule
`default_nettype wire
